// File: rtl/uart_tx_unit.sv
// Buffered 8-bit UART transmitter: small FIFO feeding an 8N1/8E/8O serialiser.
// tx_busy reports FIFO full; pushes while full are dropped and flagged in ovf.
module uart_tx_unit #(
  parameter int clk_freq  = 12_000_000,
  parameter int baud      = 115200,
  parameter int tbuf_size = 4,
  parameter int parity    = 0,
  parameter int stop_bits = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx,
  output logic       idle,
  output logic       ovf
);

  localparam int DIV = (clk_freq + baud / 2) / baud;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(tbuf_size);

  localparam logic [CW-1:0] CMAX  = CW'(DIV - 1);
  localparam logic [2:0]    SLAST = 3'(stop_bits - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [7:0]    mem [tbuf_size];
  logic [AW:0]   rd;
  logic [AW:0]   wr;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic [7:0]    head;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_n;
  logic [7:0]    shift;
  logic [7:0]    shift_n;
  logic          par_bit;
  logic          par_n;
  logic          tx_n;
  logic          last;

  function automatic logic par_of(input logic [7:0] d);
    return (parity == 2) ? ~^d : ^d;
  endfunction

  assign empty   = (rd == wr);
  assign full    = (rd[AW] != wr[AW]) &&
                   (rd[AW-1:0] == wr[AW-1:0]);
  assign push    = tx_start && !full;
  assign head    = mem[rd[AW-1:0]];
  assign tx_busy = full;
  assign idle    = empty && (state == S_IDLE);
  assign last    = (cnt == CMAX);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr[AW-1:0]] <= tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd  <= '0;
      wr  <= '0;
      ovf <= 1'b0;
    end else begin
      if (push) begin
        wr <= wr + 1'b1;
      end
      if (pop) begin
        rd <= rd + 1'b1;
      end
      if (tx_start && full) begin
        ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
      par_bit <= par_n;
      tx      <= tx_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    bit_n   = bit_idx;
    shift_n = shift;
    par_n   = par_bit;
    pop     = 1'b0;
    unique case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_n = head;
          par_n   = par_of(head);
          state_n = S_START;
        end
      end
      S_START: begin
        if (last) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (last) begin
          cnt_n   = '0;
          shift_n = shift >> 1;
          if (bit_idx == 3'd7) begin
            bit_n   = '0;
            state_n = (parity != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_n = bit_idx + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (last) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (last) begin
          cnt_n = '0;
          if (bit_idx == SLAST) begin
            bit_n = '0;
            // chain straight into the next start bit when more data waits
            if (!empty) begin
              pop     = 1'b1;
              shift_n = head;
              par_n   = par_of(head);
              state_n = S_START;
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            bit_n = bit_idx + 1'b1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // line level is a function of the state being entered, so tx stays registered
  always_comb begin
    tx_n = 1'b1;
    unique case (state_n)
      S_IDLE:   tx_n = 1'b1;
      S_START:  tx_n = 1'b0;
      S_DATA:   tx_n = shift_n[0];
      S_PARITY: tx_n = par_n;
      S_STOP:   tx_n = 1'b1;
      default:  tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_unit.sv
// Directed bench for uart_tx_unit at DIV=4: frame shape, parity, stop bits,
// back-to-back frames, FIFO overflow and wrap, and mid-frame reset.
module tb_uart_tx_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s0 = 1'b0, s1 = 1'b0, s2 = 1'b0;
  logic [7:0] d0 = '0, d1 = '0, d2 = '0;
  logic       b0, b1, b2;
  logic       tx0, tx1, tx2;
  logic       i0, i1, i2;
  logic       o0, o1, o2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_unit #(
    .clk_freq(1_000_000), .baud(250_000), .tbuf_size(4),
    .parity(0), .stop_bits(1)
  ) u0 (
    .clk(clk), .rst(rst), .tx_start(s0), .tx_data(d0),
    .tx_busy(b0), .tx(tx0), .idle(i0), .ovf(o0)
  );

  uart_tx_unit #(
    .clk_freq(1_000_000), .baud(250_000), .tbuf_size(4),
    .parity(1), .stop_bits(2)
  ) u1 (
    .clk(clk), .rst(rst), .tx_start(s1), .tx_data(d1),
    .tx_busy(b1), .tx(tx1), .idle(i1), .ovf(o1)
  );

  uart_tx_unit #(
    .clk_freq(1_000_000), .baud(250_000), .tbuf_size(4),
    .parity(2), .stop_bits(2)
  ) u2 (
    .clk(clk), .rst(rst), .tx_start(s2), .tx_data(d2),
    .tx_busy(b2), .tx(tx2), .idle(i2), .ovf(o2)
  );

  typedef struct {
    int         sel;
    logic [7:0] data;
    logic [11:0] frame;
    int         nbits;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic tx_of(input int s);
    case (s)
      0:       return tx0;
      1:       return tx1;
      default: return tx2;
    endcase
  endfunction

  function automatic logic idle_of(input int s);
    case (s)
      0:       return i0;
      1:       return i1;
      default: return i2;
    endcase
  endfunction

  task automatic drive(input int s, input logic v, input logic [7:0] d);
    case (s)
      0:       begin s0 = v; d0 = d; end
      1:       begin s1 = v; d1 = d; end
      default: begin s2 = v; d2 = d; end
    endcase
  endtask

  // Entered at the negedge following the edge where tx fell.
  task automatic check_frame(input int s, input logic [11:0] fr,
                             input int n, input string tag);
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < 4; c++) begin
        check($sformatf("%s bit%0d c%0d", tag, b, c), tx_of(s), fr[b]);
        if (b == n - 1 && c == 3)
          check($sformatf("%s idle in last stop", tag), idle_of(s), 1'b0);
        @(negedge clk);
      end
    end
  endtask

  task automatic send_one(input int s, input logic [7:0] d,
                          input logic [11:0] fr, input int n,
                          input string tag);
    @(negedge clk);
    drive(s, 1'b1, d);
    @(negedge clk);
    drive(s, 1'b0, 8'h00);
    check({tag, " tx before start"}, tx_of(s), 1'b1);
    check({tag, " idle after push"}, idle_of(s), 1'b0);
    @(negedge clk);
    check_frame(s, fr, n, tag);
    check({tag, " idle after frame"}, idle_of(s), 1'b1);
    check({tag, " tx after frame"}, tx_of(s), 1'b1);
  endtask

  function automatic logic [11:0] f8n1(input logic [7:0] d);
    return {2'b00, 1'b1, d, 1'b0};
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q [4];
    logic [7:0] v;
    logic       ok;

    vecs[0] = '{0, 8'h55, 12'b00_1_01010101_0, 10};
    vecs[1] = '{0, 8'h00, 12'b00_1_00000000_0, 10};
    vecs[2] = '{0, 8'hFF, 12'b00_1_11111111_0, 10};
    vecs[3] = '{0, 8'hA5, 12'b00_1_10100101_0, 10};
    vecs[4] = '{1, 8'h07, 12'b11_1_00000111_0, 12};
    vecs[5] = '{2, 8'h07, 12'b11_0_00000111_0, 12};
    vecs[6] = '{1, 8'h03, 12'b11_0_00000011_0, 12};
    vecs[7] = '{2, 8'h03, 12'b11_1_00000011_0, 12};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset tx0", tx0, 1'b1);
    check("reset idle0", i0, 1'b1);
    check("reset busy0", b0, 1'b0);
    check("reset ovf0", o0, 1'b0);
    check("reset tx1", tx1, 1'b1);
    check("reset tx2", tx2, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 8; k++) begin
      send_one(vecs[k].sel, vecs[k].data, vecs[k].frame,
               vecs[k].nbits, $sformatf("vec%0d", k));
    end
    check("ovf0 after singles", o0, 1'b0);

    // four consecutive pushes -> four back-to-back frames
    q[0] = 8'h41; q[1] = 8'h42; q[2] = 8'h43; q[3] = 8'h44;
    @(negedge clk);
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          drive(0, 1'b1, q[k]);
          @(negedge clk);
        end
        drive(0, 1'b0, 8'h00);
        check("b2b ovf", o0, 1'b0);
      end
      begin
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++)
          check_frame(0, f8n1(q[k]), 10, $sformatf("b2b%0d", k));
        check("b2b idle end", i0, 1'b1);
      end
    join

    // six pushes: 0x60..0x64 fit (one popped), 0x65 hits a full FIFO
    @(negedge clk);
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          drive(0, 1'b1, 8'(8'h60 + k));
          @(negedge clk);
        end
        check("ovfl busy when full", b0, 1'b1);
        check("ovfl ovf before drop", o0, 1'b0);
        drive(0, 1'b1, 8'h65);
        @(negedge clk);
        drive(0, 1'b0, 8'h00);
        check("ovfl ovf after drop", o0, 1'b1);
        check("ovfl busy still", b0, 1'b1);
      end
      begin
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 5; k++)
          check_frame(0, f8n1(8'(8'h60 + k)), 10,
                      $sformatf("ovfl%0d", k));
        check("ovfl idle end", i0, 1'b1);
        check("ovfl busy end", b0, 1'b0);
      end
    join

    for (int k = 0; k < 10; k++) begin
      v = 8'(k * 37 + 5);
      send_one(0, v, f8n1(v), 10, $sformatf("wrap%0d", k));
    end
    check("ovf sticky", o0, 1'b1);

    // mid-frame reset with two bytes still queued
    @(negedge clk);
    fork
      begin
        drive(0, 1'b1, 8'hC3);
        @(negedge clk);
        drive(0, 1'b1, 8'h3C);
        @(negedge clk);
        drive(0, 1'b1, 8'h99);
        @(negedge clk);
        drive(0, 1'b0, 8'h00);
      end
      begin
        @(negedge clk);
        @(negedge clk);
        check("rst frame started", tx0, 1'b0);
        repeat (15) @(negedge clk);
        rst = 1'b1;
      end
    join
    @(negedge clk);
    check("rst tx high", tx0, 1'b1);
    check("rst idle", i0, 1'b1);
    check("rst ovf cleared", o0, 1'b0);
    check("rst busy", b0, 1'b0);
    rst = 1'b0;
    ok = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || i0 !== 1'b1) ok = 1'b0;
    end
    check("rst no further frame", ok, 1'b1);
    send_one(0, 8'hA5, 12'b00_1_10100101_0, 10, "post-rst");
    check("post-rst ovf", o0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
